// File: rtl/vga_fb_arb_pkg.sv
// Shared types and frame geometry defaults for the framebuffer arbiter.
// VGA_FB_ARB_CPU_READ_EN adds the CPU read owner to the owner encoding.
package vga_fb_arb_pkg;

  localparam int LINE_PIXELS_DEF = 160;
  localparam int LINES_DEF       = 120;
  localparam int LINE_REPEAT_DEF = 4;
  localparam int FRAME_READS     = LINES_DEF * LINE_REPEAT_DEF * LINE_PIXELS_DEF;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_DISP   = 2'd1,
`ifdef VGA_FB_ARB_CPU_READ_EN
    OWN_CPU_RD = 2'd2,
`endif
    OWN_CPU_WR = 2'd3
  } owner_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Scanout pixel FIFO: flush, occupancy count and a registered head word.
module vga_pix_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clkin,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr,
  input  logic [W-1:0]             wdata,
  input  logic                     rd,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nx;
  logic          rd_eff, wr_eff;

  assign rd_eff  = rd && (count != '0);
  assign wr_eff  = wr && (count != FULL);
  assign rptr_nx = rptr + 1'b1;

  always_ff @(posedge clkin) begin
    if (wr_eff && !flush) mem[wptr] <= wdata;
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_eff) wptr <= wptr + 1'b1;
      if (rd_eff) rptr <= rptr_nx;
      if (wr_eff && !rd_eff)      count <= count + 1'b1;
      else if (rd_eff && !wr_eff) count <= count - 1'b1;
    end
  end

  // Head tracks the entry at rptr; a word being written this cycle bypasses the array.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
    end else if (!flush) begin
      if (count == '0) begin
        if (wr) head <= wdata;
      end else if (rd) begin
        if (count == ONE) begin
          if (wr) head <= wdata;
        end else begin
          head <= mem[rptr_nx];
        end
      end
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter between VGA scanout fetch and CPU req/ack port.
// VGA_FB_ARB_CPU_READ_EN enables CPU reads through the RAM.
//
// owner      | meaning
// OWN_NONE   | no RAM access issued this cycle
// OWN_DISP   | scanout read, data goes to the pixel FIFO
// OWN_CPU_RD | CPU read, data goes to cpu_rdata
// OWN_CPU_WR | CPU write
module vga_fb_arbiter
  import vga_fb_arb_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 8,
  parameter int LINE_PIXELS  = LINE_PIXELS_DEF,
  parameter int LINES        = LINES_DEF,
  parameter int LINE_REPEAT  = LINE_REPEAT_DEF,
  parameter int FIFO_DEPTH   = 16,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] vbase,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int COL_W  = $clog2(LINE_PIXELS + 1);
  localparam int REP_W  = $clog2(LINE_REPEAT + 1);
  localparam int ROW_W  = $clog2(LINES + 1);
  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_PIXELS - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(LINE_REPEAT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(LINES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [CNT_W+1:0]  OCC_LIM  = (CNT_W+2)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HALF     = CNT_W'(FIFO_DEPTH / 2);

  logic [COL_W-1:0]  col;
  logic [REP_W-1:0]  rep;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic              fetch_active, epoch;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cpu_busy;
  owner_t            own1, own2, grant, cpu_own;
  logic              ep1, ep2;

  logic              cpu_pend, cpu_ram, cpu_fast, cpu_grant, ack_nx;
  logic              disp1, disp2, disp_elig, urgent, fifo_wr;
  logic [1:0]        inflight;
  logic [CNT_W+1:0]  occ_sum;
  logic [CNT_W-1:0]  fifo_count;

  assign cpu_pend = cpu_req && !cpu_busy;

`ifdef VGA_FB_ARB_CPU_READ_EN
  assign cpu_ram  = cpu_pend;
  assign cpu_fast = 1'b0;
  assign cpu_own  = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
  assign ack_nx   = (own1 == OWN_CPU_WR) || (own2 == OWN_CPU_RD);
`else
  // Reads never touch the RAM: they are answered with zero one cycle after sampling.
  assign cpu_ram  = cpu_pend && cpu_we;
  assign cpu_fast = cpu_pend && !cpu_we;
  assign cpu_own  = OWN_CPU_WR;
  assign ack_nx   = (own1 == OWN_CPU_WR) || cpu_fast;
`endif

  // Only reads of the current epoch are counted; stale ones are dropped on return.
  assign disp1     = (own1 == OWN_DISP) && (ep1 == epoch);
  assign disp2     = (own2 == OWN_DISP) && (ep2 == epoch);
  assign inflight  = {1'b0, disp1} + {1'b0, disp2};
  assign occ_sum   = {2'b00, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign disp_elig = fetch_active && !frame_start && (occ_sum < OCC_LIM);
  assign urgent    = fifo_count < HALF;
  assign fifo_wr   = disp2;
  assign pix_valid = (fifo_count != '0);

  always_comb begin
    grant = OWN_NONE;
    if (cpu_ram && (wait_cnt == WAIT_MAX)) grant = cpu_own;
    else if (disp_elig && urgent)          grant = OWN_DISP;
    else if (cpu_ram)                      grant = cpu_own;
    else if (disp_elig)                    grant = OWN_DISP;
  end

  assign cpu_grant = ((grant != OWN_NONE) && (grant != OWN_DISP)) || cpu_fast;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      own1         <= OWN_NONE;
      own2         <= OWN_NONE;
      ep1          <= 1'b0;
      ep2          <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_busy     <= 1'b0;
      wait_cnt     <= '0;
      underrun     <= 1'b0;
      fetch_active <= 1'b0;
      epoch        <= 1'b0;
      col          <= '0;
      rep          <= '0;
      row          <= '0;
      row_base     <= '0;
    end else begin
      mem_en <= (grant != OWN_NONE);
      mem_we <= (grant == OWN_CPU_WR);
      if (grant == OWN_DISP) begin
        mem_addr <= row_base + ADDR_W'(col);
      end else if (grant != OWN_NONE) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      own1 <= grant;
      ep1  <= epoch;
      own2 <= own1;
      ep2  <= ep1;

      cpu_ack <= ack_nx;
      if (cpu_ack)        cpu_busy <= 1'b0;
      else if (cpu_grant) cpu_busy <= 1'b1;
      if (cpu_grant)     wait_cnt <= '0;
      else if (cpu_pend) wait_cnt <= wait_cnt + 1'b1;

      if (frame_start)                underrun <= 1'b0;
      else if (pix_rd && !pix_valid)  underrun <= 1'b1;

      if (frame_start) begin
        fetch_active <= 1'b1;
        epoch        <= ~epoch;
        col          <= '0;
        rep          <= '0;
        row          <= '0;
        row_base     <= vbase;
      end else if (grant == OWN_DISP) begin
        if (col == COL_LAST) begin
          col <= '0;
          if (rep == REP_LAST) begin
            rep      <= '0;
            row_base <= row_base + ADDR_W'(LINE_PIXELS);
            if (row == ROW_LAST) begin
              row          <= '0;
              fetch_active <= 1'b0;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            rep <= rep + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef VGA_FB_ARB_CPU_READ_EN
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n)                cpu_rdata <= '0;
    else if (own2 == OWN_CPU_RD) cpu_rdata <= mem_rdata;
  end
`else
  assign cpu_rdata = '0;
`endif

  vga_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clkin   (clkin),
    .reset_n (reset_n),
    .flush   (frame_start),
    .wr      (fifo_wr),
    .wdata   (mem_rdata),
    .rd      (pix_rd),
    .head    (pix_data),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a 3-row frame and a behavioural RAM.
module tb_vga_fb_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 8;
  localparam int LP   = 160;
  localparam int NL   = 3;
  localparam int NR   = 4;
  localparam int NPIX = LP * NL * NR;

  logic          clkin = 1'b0;
  logic          reset_n, frame_start, pix_rd, cpu_req, cpu_we;
  logic [AW-1:0] vbase, cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] pix_data, cpu_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          pix_valid, underrun, cpu_ack, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    ram [0:32767];

  int n_vec = 0;
  int n_err = 0;

  vga_fb_arbiter #(.LINES(NL)) dut (
    .clkin       (clkin),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .vbase       (vbase),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [14:0] a);
    logic [7:0] hi;
    hi  = {1'b0, a[14:8]};
    pat = a[7:0] ^ (hi * 8'h1D);
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq, first_en, last_en, first_v, n_rd, k, we_i, ack_i, n_disp, n_ack, n_en;
    logic ph;
    logic [AW-1:0] exp_a, we_addr;
    logic [DW-1:0] pd;

    for (int i = 0; i < 32768; i++) ram[i] = pat(15'(i));
    reset_n = 1'b0; frame_start = 1'b0; vbase = '0; pix_rd = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clkin);
    check_val("rst_outputs", {pix_valid, pix_data, underrun, cpu_ack, cpu_rdata,
                              mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    reset_n = 1'b1;
    n_en = 0;
    repeat (5) begin @(negedge clkin); if (mem_en) n_en++; end
    check_val("idle_no_fetch", n_en, 0);

    // fill after frame_start with no consumer
    vbase = 15'h0100; frame_start = 1'b1;
    seq = 0; first_en = -1; last_en = -1; first_v = -1; n_rd = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clkin);
      frame_start = 1'b0;
      if (mem_en) begin
        n_rd++;
        check_val("t1_addr", mem_addr, 15'h0100 + seq);
        seq++;
        if (first_en < 0) first_en = i;
        last_en = i;
      end
      if (pix_valid && first_v < 0) begin
        first_v = i;
        check_val("t1_first_pix", pix_data, pat(15'h0100));
      end
    end
    check_val("t1_first_en", first_en, 2);
    check_val("t1_last_en", last_en, 17);
    check_val("t1_reads", seq, 16);
    check_val("t1_first_valid", first_v, 4);

    // full frame consumed at one pixel every other cycle
    k = 0; ph = 1'b0;
    for (int c = 0; c < 8000 && k < NPIX; c++) begin
      @(negedge clkin);
      if (mem_en && !mem_we) n_rd++;
      if (ph) begin
        check_val("t2_valid", pix_valid, 1'b1);
        if (pix_valid) begin
          exp_a = 15'h0100 + (k / (LP * NR)) * LP + (k % LP);
          check_val("t2_pix", pix_data, pat(exp_a));
        end
        pix_rd = 1'b1;
        k++;
      end else begin
        pix_rd = 1'b0;
      end
      ph = ~ph;
    end
    check_val("t2_count", k, NPIX);
    for (int c = 0; c < 30; c++) begin
      @(negedge clkin);
      pix_rd = 1'b0;
      if (mem_en && !mem_we) n_rd++;
    end
    check_val("t2_reads", n_rd, NPIX);
    check_val("t2_underrun", underrun, 1'b0);
    check_val("t2_drained", pix_valid, 1'b0);

    // CPU write then read while idle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0005; cpu_wdata = 8'hA5;
    @(negedge clkin);
    check_val("t3_wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 15'h0005, 8'hA5});
    check_val("t3_wr_early_ack", cpu_ack, 1'b0);
    @(negedge clkin);
    check_val("t3_wr_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    @(negedge clkin);
    check_val("t3_ack_pulse", cpu_ack, 1'b0);
    check_val("t3_ram", ram[5], 8'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
`ifdef VGA_FB_ARB_CPU_READ_EN
    @(negedge clkin);
    check_val("t3_rd_mem", {mem_en, mem_we, mem_addr}, {2'b10, 15'h0005});
    @(negedge clkin);
    check_val("t3_rd_early_ack", cpu_ack, 1'b0);
    @(negedge clkin);
    check_val("t3_rd_ack", {cpu_ack, cpu_rdata}, {1'b1, 8'hA5});
    cpu_req = 1'b0;
`else
    @(negedge clkin);
    check_val("t3_rd_fast_ack", {cpu_ack, cpu_rdata, mem_en}, {1'b1, 8'h00, 1'b0});
    cpu_req = 1'b0;
`endif
    @(negedge clkin);
    check_val("t3_rd_ack_pulse", cpu_ack, 1'b0);

    // urgent scanout against a held CPU write
    vbase = 15'h0200; frame_start = 1'b1;
    @(negedge clkin);
    frame_start = 1'b0;
    for (int c = 0; c < 10 && !pix_valid; c++) @(negedge clkin);
    check_val("t4_stream_up", pix_valid, 1'b1);
    pix_rd = 1'b1;
    repeat (10) @(negedge clkin);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 8'h3C;
    we_i = -1; ack_i = -1; n_disp = 0; we_addr = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clkin);
      if (i <= 8 && mem_en && !mem_we) n_disp++;
      if (mem_en && mem_we && we_i < 0) begin we_i = i; we_addr = mem_addr; end
      if (cpu_ack && ack_i < 0) begin ack_i = i; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0; pix_rd = 1'b0;
    check_val("t4_disp_wins", n_disp, 8);
    check_val("t4_forced_grant", we_i, 9);
    check_val("t4_grant_addr", we_addr, 15'h0010);
    check_val("t4_ack_latency", ack_i, 10);

    // frame_start with display reads in flight and a CPU write pending
    vbase = 15'h0300; frame_start = 1'b1;
    @(negedge clkin);
    frame_start = 1'b0;
    @(negedge clkin);
    @(negedge clkin);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 8'h77;
    @(negedge clkin);
    check_val("t5_old_pix", {pix_valid, pix_data}, {1'b1, pat(15'h0300)});
    vbase = 15'h0400; frame_start = 1'b1;
    @(negedge clkin);
    frame_start = 1'b0;
    check_val("t5_flushed", pix_valid, 1'b0);
    check_val("t5_cpu_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 15'h0020, 8'h77});
    @(negedge clkin);
    check_val("t5_new_addr", {mem_en, mem_we, mem_addr}, {2'b10, 15'h0400});
    check_val("t5_cpu_ack", cpu_ack, 1'b1);
    check_val("t5_no_stale_a", pix_valid, 1'b0);
    cpu_req = 1'b0;
    @(negedge clkin);
    check_val("t5_no_stale_b", pix_valid, 1'b0);
    @(negedge clkin);
    check_val("t5_new_pix", {pix_valid, pix_data}, {1'b1, pat(15'h0400)});

    // underrun set, held and cleared
    vbase = 15'h0500; frame_start = 1'b1;
    @(negedge clkin);
    pix_rd = 1'b1;
    @(negedge clkin);
    check_val("t6_flush_wins", underrun, 1'b0);
    frame_start = 1'b0;
    pd = pix_data;
    @(negedge clkin);
    check_val("t6_underrun_set", underrun, 1'b1);
    check_val("t6_pix_hold", pix_data, pd);
    pix_rd = 1'b0;
    repeat (12) @(negedge clkin);
    check_val("t6_underrun_held", {underrun, pix_valid}, 2'b11);
    frame_start = 1'b1;
    @(negedge clkin);
    frame_start = 1'b0;
    check_val("t6_underrun_clr", underrun, 1'b0);

    // reset mid CPU write
    repeat (25) @(negedge clkin);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 8'h5E;
    @(negedge clkin);
    check_val("t7_wr_issued", {mem_en, mem_we, mem_addr}, {2'b11, 15'h0030});
    #2 reset_n = 1'b0;
    #1;
    check_val("t7_async_clear", {pix_valid, pix_data, underrun, cpu_ack, cpu_rdata,
                                 mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    cpu_req = 1'b0;
    @(negedge clkin);
    reset_n = 1'b1;
    n_ack = 0; n_en = 0;
    repeat (6) begin
      @(negedge clkin);
      if (cpu_ack) n_ack++;
      if (mem_en) n_en++;
    end
    check_val("t7_no_ack", n_ack, 0);
    check_val("t7_fetch_idle", n_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
